// File: rtl/pport_pkg.sv
// Shared definitions for the multi-channel parallel port: per-channel register
// offsets and the channel-index width helper.
package pport_pkg;

  typedef enum logic [2:0] {
    REG_DIR  = 3'd0,
    REG_PIN  = 3'd1,
    REG_PORT = 3'd2,
    REG_SET  = 3'd3,
    REG_CLR  = 3'd4,
    REG_TOG  = 3'd5,
    REG_EDGE = 3'd6,
    REG_MASK = 3'd7
  } reg_e;

  // Channel field is at least one bit wide even for a single port.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pport_channel.sv
// One bidirectional port: direction/output/mask registers, input synchroniser,
// rising-edge capture with W1C clear, read mux and local interrupt term.
module pport_channel
  import pport_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  reg_e             reg_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] port_out,
  output logic [WIDTH-1:0] dir_out,
  output logic [WIDTH-1:0] rd_data,
  output logic             ch_irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] dir_q, port_q, mask_q, edge_q, prev_q;
  logic [WIDTH-1:0] pin, rise, w1c;

  assign pin  = sync_q[SYNC_STAGES-1];
  assign rise = pin & ~prev_q;
  assign w1c  = (wr_en && reg_sel == REG_EDGE) ? wr_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q  <= '0;
      port_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
      prev_q <= '0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_DIR:  dir_q  <= wr_data;
          REG_PORT: port_q <= wr_data;
          REG_SET:  port_q <= port_q | wr_data;
          REG_CLR:  port_q <= port_q & ~wr_data;
          REG_TOG:  port_q <= port_q ^ wr_data;
          REG_MASK: mask_q <= wr_data;
          default:  ;
        endcase
      end
      prev_q <= pin;
      // OR-ing rise after the clear lets a same-cycle new edge survive its W1C.
      edge_q <= (edge_q & ~w1c) | rise;
    end
  end

  always_comb begin
    rd_data = port_q;
    case (reg_sel)
      REG_DIR:  rd_data = dir_q;
      REG_PIN:  rd_data = pin;
      REG_EDGE: rd_data = edge_q;
      REG_MASK: rd_data = mask_q;
      default:  rd_data = port_q;
    endcase
  end

  assign port_out = port_q;
  assign dir_out  = dir_q;
  assign ch_irq   = |(edge_q & mask_q);

endmodule

// File: rtl/pport_multi.sv
// N_CH-channel bidirectional parallel port on an Avalon-MM slave: address
// decode, registered read data (latency 1) and registered interrupt OR.
module pport_multi
  import pport_pkg::*;
#(
  parameter  int N_CH        = 3,
  parameter  int WIDTH       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_BITS     = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CH_BITS+2:0]    avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  input  logic [N_CH*WIDTH-1:0] pp_in,
  output logic [N_CH*WIDTH-1:0] pp_out,
  output logic [N_CH*WIDTH-1:0] pp_oe,
  output logic                  irq
);

  logic [CH_BITS-1:0] ch_sel;
  reg_e               reg_sel;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   ch_rd [N_CH];
  logic [N_CH-1:0]    ch_irq;
  logic [WIDTH-1:0]   rd_mux;
  logic               unused_wd;

  assign ch_sel    = avs_address[CH_BITS+2:3];
  assign reg_sel   = reg_e'(avs_address[2:0]);
  assign wr_data   = avs_writedata[WIDTH-1:0];
  assign unused_wd = ^avs_writedata;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pport_channel #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (avs_write && (ch_sel == CH_BITS'(c))),
      .reg_sel  (reg_sel),
      .wr_data  (wr_data),
      .pad_in   (pp_in[c*WIDTH +: WIDTH]),
      .port_out (pp_out[c*WIDTH +: WIDTH]),
      .dir_out  (pp_oe[c*WIDTH +: WIDTH]),
      .rd_data  (ch_rd[c]),
      .ch_irq   (ch_irq[c])
    );
  end

  // Unpopulated channel indices fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (ch_sel == CH_BITS'(c)) rd_mux = ch_rd[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (avs_read) avs_readdata <= 32'(rd_mux);
      irq <= |ch_irq;
    end
  end

endmodule

// File: tb/tb_pport_multi.sv
// Self-checking bench for pport_multi: directed table, multi-cycle corner
// sequences and randomized traffic against a behavioural register model.
module tb_pport_multi;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            avs_read = 1'b0;
  logic            avs_write = 1'b0;
  logic [AW-1:0]   avs_address = '0;
  logic [31:0]     avs_writedata = '0;
  logic [31:0]     avs_readdata;
  logic [N*W-1:0]  pp_in = '0;
  logic [N*W-1:0]  pp_out;
  logic [N*W-1:0]  pp_oe;
  logic            irq;

  always #5 clk = ~clk;

  pport_multi #(.N_CH(N), .WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .pp_in         (pp_in),
    .pp_out        (pp_out),
    .pp_oe         (pp_oe),
    .irq           (irq)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: registers as arrays, pads seen through a delay line.
  logic [W-1:0]   m_dir  [N];
  logic [W-1:0]   m_port [N];
  logic [W-1:0]   m_mask [N];
  logic [W-1:0]   m_edge [N];
  logic [N*W-1:0] samp   [S+1];
  logic           m_irq;
  logic [31:0]    m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < N; c++) begin
      m_dir[c] = '0; m_port[c] = '0; m_mask[c] = '0; m_edge[c] = '0;
    end
    for (int i = 0; i <= S; i++) samp[i] = '0;
    m_irq = 1'b0;
    m_rd  = '0;
  endtask

  function automatic logic [W-1:0] m_reg(input int ch, input int r);
    logic [N*W-1:0] p;
    p = samp[S-1];
    case (r)
      0:       return m_dir[ch];
      1:       return p[ch*W +: W];
      6:       return m_edge[ch];
      7:       return m_mask[ch];
      default: return m_port[ch];
    endcase
  endfunction

  task automatic model_step();
    int             ch, r;
    logic [W-1:0]   wd, rise, w1c;
    logic [N*W-1:0] pin, prv;
    logic           any;
    ch  = int'(avs_address[4:3]);
    r   = int'(avs_address[2:0]);
    wd  = avs_writedata[W-1:0];
    pin = samp[S-1];
    prv = samp[S];
    if (avs_read) m_rd = (ch < N) ? 32'(m_reg(ch, r)) : 32'd0;
    any = 1'b0;
    for (int c = 0; c < N; c++) any |= |(m_edge[c] & m_mask[c]);
    m_irq = any;
    for (int c = 0; c < N; c++) begin
      rise = pin[c*W +: W] & ~prv[c*W +: W];
      w1c  = (avs_write && ch == c && r == 6) ? wd : '0;
      m_edge[c] = (m_edge[c] & ~w1c) | rise;
    end
    if (avs_write && ch < N) begin
      case (r)
        0: m_dir[ch]  = wd;
        2: m_port[ch] = wd;
        3: m_port[ch] = m_port[ch] | wd;
        4: m_port[ch] = m_port[ch] & ~wd;
        5: m_port[ch] = m_port[ch] ^ wd;
        7: m_mask[ch] = wd;
        default: ;
      endcase
    end
    for (int i = S; i > 0; i--) samp[i] = samp[i-1];
    samp[0] = pp_in;
  endtask

  task automatic check_all();
    logic [N*W-1:0] eo, ee;
    for (int c = 0; c < N; c++) begin
      eo[c*W +: W] = m_port[c];
      ee[c*W +: W] = m_dir[c];
    end
    chk("model pp_out", 32'(pp_out), 32'(eo));
    chk("model pp_oe", 32'(pp_oe), 32'(ee));
    chk("model irq", 32'(irq), 32'(m_irq));
    chk("model readdata", avs_readdata, m_rd);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic bus(input bit rd, input bit wr, input int ch, input int r, input logic [31:0] wd);
    avs_read      = rd;
    avs_write     = wr;
    avs_address   = {2'(ch), 3'(r)};
    avs_writedata = wd;
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic bus_wr(input int ch, input int r, input logic [31:0] wd);
    bus(1'b0, 1'b1, ch, r, wd);
  endtask

  task automatic bus_rd(input int ch, input int r);
    bus(1'b1, 1'b0, ch, r, 32'd0);
  endtask

  typedef struct {
    bit        rd;
    bit        wr;
    int        ch;
    int        r;
    bit [31:0] wd;
    bit [7:0]  exp_out;
    bit [7:0]  exp_oe;
    bit [31:0] exp_rd;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 1, 1, 0, 32'h0000_00FF,   8'hFF, 8'hFF, 32'h0};
    tbl[0].exp_out = 8'h00;
    tbl[1]  = '{0, 1, 1, 2, 32'h0000_00A5,   8'hA5, 8'hFF, 32'h0};
    tbl[2]  = '{0, 1, 1, 3, 32'h0000_000A,   8'hAF, 8'hFF, 32'h0};
    tbl[3]  = '{0, 1, 1, 4, 32'h0000_0081,   8'h2E, 8'hFF, 32'h0};
    tbl[4]  = '{0, 1, 1, 5, 32'h0000_0003,   8'h2D, 8'hFF, 32'h0};
    tbl[5]  = '{1, 0, 1, 2, 32'h0,           8'h2D, 8'hFF, 32'h2D};
    tbl[6]  = '{1, 0, 1, 3, 32'h0,           8'h2D, 8'hFF, 32'h2D};
    tbl[7]  = '{0, 1, 1, 3, 32'hFFFF_FF00,   8'h2D, 8'hFF, 32'h2D};
    tbl[8]  = '{1, 0, 1, 0, 32'h0,           8'h2D, 8'hFF, 32'hFF};
    tbl[9]  = '{1, 1, 1, 2, 32'h0000_0011,   8'h11, 8'hFF, 32'h2D};
    tbl[10] = '{1, 0, 1, 2, 32'h0,           8'h11, 8'hFF, 32'h11};
    tbl[11] = '{0, 1, 3, 2, 32'h0000_00FF,   8'h11, 8'hFF, 32'h11};
    tbl[12] = '{1, 0, 3, 2, 32'h0,           8'h11, 8'hFF, 32'h0};
    tbl[13] = '{1, 0, 3, 0, 32'h0,           8'h11, 8'hFF, 32'h0};

    m_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst readdata", avs_readdata, 32'h0);
    chk("rst pp_oe", 32'(pp_oe), 32'h0);
    chk("rst pp_out", 32'(pp_out), 32'h0);
    chk("rst irq", 32'(irq), 32'h0);
    reset_n = 1'b1;

    for (int ch = 0; ch < N; ch++)
      for (int r = 0; r < 8; r++) begin
        bus_rd(ch, r);
        chk($sformatf("rst read ch%0d r%0d", ch, r), avs_readdata, 32'h0);
      end

    foreach (tbl[i]) begin
      bus(tbl[i].rd, tbl[i].wr, tbl[i].ch, tbl[i].r, tbl[i].wd);
      chk($sformatf("tbl[%0d] pp_out ch1", i), 32'(pp_out[15:8]), 32'(tbl[i].exp_out));
      chk($sformatf("tbl[%0d] pp_oe ch1", i), 32'(pp_oe[15:8]), 32'(tbl[i].exp_oe));
      chk($sformatf("tbl[%0d] readdata", i), avs_readdata, tbl[i].exp_rd);
    end

    // Pad rise on ch0 bit 2: EDGE set on edge 3, irq on edge 4.
    bus_wr(0, 7, 32'h04);
    pp_in[2] = 1'b1;
    tick(); chk("edge c1 irq", 32'(irq), 32'h0);
    tick(); chk("edge c2 irq", 32'(irq), 32'h0);
    avs_read = 1'b1; avs_address = {2'd0, 3'd6};
    tick();
    chk("edge c3 EDGE pre", avs_readdata, 32'h0);
    chk("edge c3 irq", 32'(irq), 32'h0);
    tick();
    chk("edge c4 EDGE", avs_readdata, 32'h04);
    chk("edge c4 irq", 32'(irq), 32'h1);
    avs_read = 1'b0;
    bus_wr(0, 6, 32'h04);
    chk("w1c irq +1", 32'(irq), 32'h1);
    tick();
    chk("w1c irq +2", 32'(irq), 32'h0);

    // Set wins: ch2 bit 7 rise on the same edge as its W1C.
    pp_in[23] = 1'b1;
    repeat (4) tick();
    pp_in[23] = 1'b0;
    repeat (3) tick();
    bus_rd(2, 6);
    chk("sw first EDGE", avs_readdata, 32'h80);
    pp_in[23] = 1'b1;
    tick(); tick();
    bus_wr(2, 6, 32'h80);
    bus_rd(2, 6);
    chk("set wins EDGE", avs_readdata, 32'h80);
    bus_wr(2, 7, 32'h80);
    tick();
    chk("mask ch2 irq", 32'(irq), 32'h1);
    bus_wr(2, 6, 32'h80);
    tick();
    chk("w1c ch2 irq", 32'(irq), 32'h0);
    bus_rd(2, 6);
    chk("w1c ch2 EDGE", avs_readdata, 32'h0);

    // Async reset in the middle of a write burst.
    pp_in[0] = 1'b1;
    bus_wr(0, 7, 32'h05);
    repeat (3) tick();
    chk("pre-rst irq", 32'(irq), 32'h1);
    bus_wr(0, 0, 32'hFF);
    bus_wr(0, 2, 32'hFF);
    bus_rd(1, 0);
    chk("pre-rst pp_out ch0", 32'(pp_out[7:0]), 32'hFF);
    chk("pre-rst readdata", avs_readdata, 32'hFF);
    avs_write = 1'b1; avs_address = {2'd0, 3'd5}; avs_writedata = 32'h0F;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("async rst pp_out", 32'(pp_out), 32'h0);
    chk("async rst pp_oe", 32'(pp_oe), 32'h0);
    chk("async rst irq", 32'(irq), 32'h0);
    chk("async rst readdata", avs_readdata, 32'h0);
    m_reset();
    avs_write = 1'b0;
    @(posedge clk); #1;
    chk("in rst pp_out", 32'(pp_out), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 500; i++) begin
      avs_read      = 1'($urandom_range(0, 1));
      avs_write     = ($urandom_range(0, 2) == 0);
      avs_address   = AW'($urandom);
      avs_writedata = $urandom;
      if ($urandom_range(0, 3) == 0) pp_in = (N*W)'($urandom);
      tick();
    end
    avs_read  = 1'b0;
    avs_write = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
